// File: rtl/fifo_ddr3_write_arbiter.sv
// Round-robin drain of NUM_CH capture FIFOs into the DDR3 MIG app write port.
// Each channel writes single-beat words into its own wrapping ring region.
module fifo_ddr3_write_arbiter #(
  parameter int          NUM_CH      = 2,
  parameter int          DATA_W      = 80,
  parameter int          APP_DATA_W  = 128,
  parameter int          ADDR_W      = 29,
  parameter int          BURST_LEN   = 16,
  parameter int          ADDR_INC    = 8,
  parameter int          REGION_LOG2 = 24,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                     clk350_p,
  input  logic                     reset_n_p,
  input  logic                     enable_p,
  input  logic                     init_calib_complete_p,
  input  logic [NUM_CH-1:0]        fifo_empty_p,
  input  logic [NUM_CH*DATA_W-1:0] fifo_dout_p,
  output logic [NUM_CH-1:0]        fifo_rd_en_p,
  input  logic                     app_rdy_p,
  input  logic                     app_wdf_rdy_p,
  output logic                     app_en_p,
  output logic [2:0]               app_cmd_p,
  output logic [ADDR_W-1:0]        app_addr_p,
  output logic [APP_DATA_W-1:0]    app_wdf_data_p,
  output logic                     app_wdf_wren_p,
  output logic                     app_wdf_end_p,
  output logic [APP_DATA_W/8-1:0]  app_wdf_mask_p,
  output logic                     busy_p,
  output logic [2:0]               cur_ch_p,
  output logic [NUM_CH-1:0]        wrap_p,
  output logic [31:0]              words_written_p
);

  localparam int unsigned NCH    = NUM_CH;
  localparam int unsigned DBYTES = DATA_W / 8;
  localparam int unsigned ABYTES = APP_DATA_W / 8;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_READ,
    S_LATCH,
    S_ISSUE,
    S_NEXT
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cur_q, cur_d;
  logic [REGION_LOG2-1:0] ptr_q [NUM_CH];
  logic [REGION_LOG2-1:0] ptr_d [NUM_CH];
  logic [8:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   en_q, en_d;
  logic                   wren_q, wren_d;
  logic [NUM_CH-1:0]      wrap_q, wrap_d;
  logic [31:0]            words_q, words_d;

  logic                   cur_nonempty;
  logic [DATA_W-1:0]      cur_word;
  logic [REGION_LOG2-1:0] cur_ptr;
  logic [ADDR_W-1:0]      cur_base;
  logic                   sel_found;
  logic [2:0]             sel_ch;
  int unsigned            cur_int;

  // Per-channel views of the granted channel, decoded without variable bit-selects.
  always_comb begin
    cur_nonempty = 1'b0;
    cur_word     = '0;
    cur_ptr      = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (cur_q == 3'(c)) begin
        cur_nonempty = ~fifo_empty_p[c];
        cur_word     = fifo_dout_p[c*DATA_W +: DATA_W];
        cur_ptr      = ptr_q[c];
      end
    end
    cur_base = BASE + (ADDR_W'(cur_q) << REGION_LOG2);
  end

  // Round-robin search starting at the channel after the last grant.
  always_comb begin
    cur_int   = {29'd0, cur_q};
    sel_found = 1'b0;
    sel_ch    = cur_q;
    for (int unsigned k = 1; k <= NCH; k++) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (!sel_found && (c == ((cur_int + k) % NCH)) && !fifo_empty_p[c]) begin
          sel_found = 1'b1;
          sel_ch    = 3'(c);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    en_d    = en_q;
    wren_d  = wren_q;
    wrap_d  = '0;
    words_d = words_q;
    case (state_q)
      S_IDLE: begin
        if (enable_p && init_calib_complete_p && (|(~fifo_empty_p)))
          state_d = S_SELECT;
      end
      S_SELECT: begin
        if (sel_found) begin
          cur_d   = sel_ch;
          cnt_d   = '0;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        data_d  = cur_word;
        addr_d  = cur_base + ADDR_W'(cur_ptr);
        en_d    = 1'b1;
        wren_d  = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Command and data handshakes complete independently; the word is done when both have.
        if (en_q && app_rdy_p)       en_d   = 1'b0;
        if (wren_q && app_wdf_rdy_p) wren_d = 1'b0;
        if ((!en_q || app_rdy_p) && (!wren_q || app_wdf_rdy_p)) begin
          for (int unsigned c = 0; c < NCH; c++) begin
            if (cur_q == 3'(c)) begin
              ptr_d[c]  = ptr_q[c] + REGION_LOG2'(ADDR_INC);
              wrap_d[c] = (ptr_d[c] == '0);
            end
          end
          words_d = words_q + 32'd1;
          cnt_d   = cnt_q + 9'd1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if ((cnt_q < 9'(BURST_LEN)) && cur_nonempty && enable_p)
          state_d = S_READ;
        else if (!enable_p)
          state_d = S_IDLE;
        else
          state_d = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk350_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state_q <= S_IDLE;
      cur_q   <= 3'(NUM_CH - 1);
      ptr_q   <= '{default: '0};
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      wrap_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      wren_q  <= wren_d;
      wrap_q  <= wrap_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++)
      fifo_rd_en_p[c] = (state_q == S_READ) && (cur_q == 3'(c));
    for (int unsigned b = 0; b < ABYTES; b++)
      app_wdf_mask_p[b] = (b >= DBYTES);
  end

  assign app_en_p        = en_q;
  assign app_cmd_p       = 3'b000;
  assign app_addr_p      = addr_q;
  assign app_wdf_data_p  = APP_DATA_W'(data_q);
  assign app_wdf_wren_p  = wren_q;
  assign app_wdf_end_p   = wren_q;
  assign busy_p          = (state_q != S_IDLE);
  assign cur_ch_p        = cur_q;
  assign wrap_p          = wrap_q;
  assign words_written_p = words_q;

endmodule

// File: tb/tb_fifo_ddr3_write_arbiter.sv
// Scoreboard bench: a queue-based round-robin model predicts every DDR3 write,
// a monitor pops and compares each completed write under random back-pressure.
module tb_fifo_ddr3_write_arbiter;

  localparam int          NUM_CH      = 3;
  localparam int          DATA_W      = 40;
  localparam int          APP_DATA_W  = 64;
  localparam int          ADDR_W      = 29;
  localparam int          BURST_LEN   = 4;
  localparam int          ADDR_INC    = 8;
  localparam int          REGION_LOG2 = 6;
  localparam int unsigned BASE_ADDR   = 32'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n, enable, calib;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_dout;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic                     app_rdy, app_wdf_rdy;
  logic                     app_en, app_wdf_wren, app_wdf_end, busy;
  logic [2:0]               app_cmd, cur_ch;
  logic [ADDR_W-1:0]        app_addr;
  logic [APP_DATA_W-1:0]    app_wdf_data;
  logic [APP_DATA_W/8-1:0]  app_wdf_mask;
  logic [NUM_CH-1:0]        wrap;
  logic [31:0]              words_written;

  fifo_ddr3_write_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .APP_DATA_W(APP_DATA_W), .ADDR_W(ADDR_W),
    .BURST_LEN(BURST_LEN), .ADDR_INC(ADDR_INC), .REGION_LOG2(REGION_LOG2),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk350_p(clk), .reset_n_p(rst_n), .enable_p(enable),
    .init_calib_complete_p(calib), .fifo_empty_p(fifo_empty),
    .fifo_dout_p(fifo_dout), .fifo_rd_en_p(fifo_rd_en),
    .app_rdy_p(app_rdy), .app_wdf_rdy_p(app_wdf_rdy), .app_en_p(app_en),
    .app_cmd_p(app_cmd), .app_addr_p(app_addr), .app_wdf_data_p(app_wdf_data),
    .app_wdf_wren_p(app_wdf_wren), .app_wdf_end_p(app_wdf_end),
    .app_wdf_mask_p(app_wdf_mask), .busy_p(busy), .cur_ch_p(cur_ch),
    .wrap_p(wrap), .words_written_p(words_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source FIFOs with 1-cycle read latency.
  logic [DATA_W-1:0] fq [NUM_CH][$];
  initial begin
    fifo_empty = '1;
    fifo_dout  = '0;
  end
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (fifo_rd_en[c] && fq[c].size() > 0)
        fifo_dout[c*DATA_W +: DATA_W] <= fq[c].pop_front();
      fifo_empty[c] <= (fq[c].size() == 0);
    end
  end

  task automatic push(input int c, input logic [DATA_W-1:0] d);
    fq[c].push_back(d);
  endtask

  // Reference model of arbitration and per-channel ring pointers.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t        exp_q[$];
  int unsigned m_cur;
  int unsigned m_ptr   [NUM_CH];
  int unsigned m_wraps [NUM_CH];
  int unsigned m_words;
  int unsigned obs_wraps [NUM_CH];

  task automatic model_reset();
    m_cur   = NUM_CH - 1;
    m_words = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_ptr[c] = 0; m_wraps[c] = 0; obs_wraps[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic predict();
    logic [DATA_W-1:0] mq [NUM_CH][$];
    int found;
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) mq[c] = fq[c];
    while (1) begin
      found = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        int c = (int'(m_cur) + k) % NUM_CH;
        if (found < 0 && mq[c].size() > 0) found = c;
      end
      if (found < 0) break;
      m_cur = found;
      for (int n = 0; n < BURST_LEN && mq[found].size() > 0; n++) begin
        e.addr = ADDR_W'(BASE_ADDR + found * (1 << REGION_LOG2) + m_ptr[found]);
        e.data = mq[found].pop_front();
        exp_q.push_back(e);
        m_ptr[found] = (m_ptr[found] + ADDR_INC) % (1 << REGION_LOG2);
        if (m_ptr[found] == 0) m_wraps[found]++;
        m_words++;
      end
    end
  endtask

  // Back-pressure driver: 0 = always ready, 1 = random, 2 = data path stalled.
  int rdy_mode = 0;
  initial begin
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
        1:       begin app_rdy = ($urandom_range(0, 3) != 0); app_wdf_rdy = ($urandom_range(0, 2) != 0); end
        default: begin app_rdy = 1'b1; app_wdf_rdy = 1'b0; end
      endcase
    end
  end

  logic [APP_DATA_W/8-1:0] exp_mask;
  initial for (int b = 0; b < APP_DATA_W/8; b++) exp_mask[b] = (b * 8 >= DATA_W);

  // Monitor: samples on the falling edge, the handshake values the next rising edge will see.
  initial begin
    logic cmd_done, dat_done, seen;
    logic [ADDR_W-1:0] got_addr, h_addr;
    logic [APP_DATA_W-1:0] got_data, h_data;
    exp_t e;
    cmd_done = 0; dat_done = 0; seen = 0;
    got_addr = '0; h_addr = '0; got_data = '0; h_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_done = 0; dat_done = 0; seen = 0;
        continue;
      end
      if (fifo_rd_en != '0) begin
        check("rd_en_onehot", 64'($onehot(fifo_rd_en)), 64'd1);
        check("rd_en_on_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
      end
      for (int c = 0; c < NUM_CH; c++) if (wrap[c]) obs_wraps[c]++;
      if (cmd_done) check("app_en_after_accept", 64'(app_en), 64'd0);
      if (dat_done) check("wren_after_accept", 64'(app_wdf_wren), 64'd0);
      if (app_en || app_wdf_wren) begin
        check("app_cmd", 64'(app_cmd), 64'd0);
        check("wdf_end", 64'(app_wdf_end), 64'(app_wdf_wren));
        check("wdf_mask", 64'(app_wdf_mask), 64'(exp_mask));
        if (!seen) begin
          seen = 1; h_addr = app_addr; h_data = app_wdf_data;
        end else begin
          check("addr_stable", 64'(app_addr), 64'(h_addr));
          check("data_stable", 64'(app_wdf_data), 64'(h_data));
        end
      end
      if (app_en && app_rdy) begin cmd_done = 1; got_addr = app_addr; end
      if (app_wdf_wren && app_wdf_rdy) begin dat_done = 1; got_data = app_wdf_data; end
      if (cmd_done && dat_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", got_addr, got_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(got_addr), 64'(e.addr));
          check("write_data", 64'(got_data), 64'(e.data));
        end
        cmd_done = 0; dat_done = 0; seen = 0;
      end
    end
  end

  function automatic bit fifos_have_data();
    for (int c = 0; c < NUM_CH; c++) if (fq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain();
    int cyc = 0;
    while ((fifos_have_data() || busy || exp_q.size() > 0 || fifo_empty != '1) && cyc < 5000) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending writes expected 0", exp_q.size());
    end
    @(negedge clk);
    check("words_written", 64'(words_written), 64'(m_words));
    check("cur_ch", 64'(cur_ch), 64'(m_cur));
    for (int c = 0; c < NUM_CH; c++) check("wrap_count", 64'(obs_wraps[c]), 64'(m_wraps[c]));
  endtask

  task automatic check_reset_outputs();
    check("rst_app_en", 64'(app_en), 64'd0);
    check("rst_wren", 64'(app_wdf_wren), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(app_addr), 64'd0);
    check("rst_data", 64'(app_wdf_data), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_cur_ch", 64'(cur_ch), 64'(NUM_CH - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, gap, cyc;
    logic [63:0] r;
    rst_n = 1'b0; enable = 1'b0; calib = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;

    // Calibration gating, then rd_en latency and spacing with rdy held high.
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(1, DATA_W'(40'hA0_0000_0000 + i));
    enable = 1'b1;
    predict();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("calib_low_busy", 64'(busy), 64'd0);
      check("calib_low_rd_en", 64'(fifo_rd_en), 64'd0);
    end
    @(posedge clk); #1 calib = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (fifo_rd_en != '0) break;
      lat++;
    end
    check("calib_to_rd_en", 64'(lat), 64'd2);
    gap = 0;
    while (gap < 20) begin
      @(negedge clk); gap++;
      if (fifo_rd_en != '0) break;
    end
    check("rd_en_spacing", 64'(gap), 64'd4);
    wait_drain();

    // Reset while a word is stuck in ISSUE: the in-flight word is lost, pointers restart.
    enable = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(0, DATA_W'(40'hB0_0000_0000 + i));
    for (int i = 0; i < 2; i++) push(2, DATA_W'(40'hC0_0000_0000 + i));
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    cyc = 0;
    while (!app_wdf_wren && cyc < 100) begin @(negedge clk); cyc++; end
    check("issue_reached", 64'(app_wdf_wren), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    enable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 predict();
    rdy_mode = 1;
    rst_n = 1'b1;
    enable = 1'b1;
    wait_drain();

    // Randomised rounds under random back-pressure; regions wrap every 8 words.
    for (int round = 0; round < 12; round++) begin
      enable = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CH; c++) begin
        int n = $urandom_range(0, 11);
        for (int i = 0; i < n; i++) begin
          r = {$urandom, $urandom};
          push(c, r[DATA_W-1:0]);
        end
      end
      repeat (2) @(posedge clk);
      #1 predict();
      enable = 1'b1;
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
